// File: rtl/udp_tx_packetizer.sv
// Buffers one datagram from a byte stream, then emits a UDP header followed by its payload.
// Define UDP_TX_PACKETIZER_STATS_EN to add datagram/byte/drop statistics counters.
module udp_tx_packetizer #(
   parameter int MAX_PAYLOAD    = 1024,
   parameter int TIMEOUT_CYCLES = 125000,
   parameter int IP_TTL         = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   input  logic [31:0] local_ip,
   input  logic [31:0] remote_ip,
   input  logic [15:0] local_port,
   input  logic [15:0] remote_port,
   output logic        m_udp_hdr_valid,
   input  logic        m_udp_hdr_ready,
   output logic [5:0]  m_udp_ip_dscp,
   output logic [1:0]  m_udp_ip_ecn,
   output logic [7:0]  m_udp_ip_ttl,
   output logic [31:0] m_udp_ip_source_ip,
   output logic [31:0] m_udp_ip_dest_ip,
   output logic [15:0] m_udp_source_port,
   output logic [15:0] m_udp_dest_port,
   output logic [15:0] m_udp_length,
   output logic [15:0] m_udp_checksum,
   output logic [7:0]  m_udp_payload_axis_tdata,
   output logic        m_udp_payload_axis_tvalid,
   input  logic        m_udp_payload_axis_tready,
   output logic        m_udp_payload_axis_tlast,
   output logic        m_udp_payload_axis_tuser
`ifdef UDP_TX_PACKETIZER_STATS_EN
   ,
   output logic [31:0] stat_datagrams,
   output logic [31:0] stat_bytes,
   output logic [15:0] stat_drops
`endif
);

   localparam int AW = $clog2(MAX_PAYLOAD);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(MAX_PAYLOAD - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_HDR, S_PAYLOAD} state_t;

   state_t        state, state_next;
   logic [7:0]    buffer [MAX_PAYLOAD];
   logic [CW-1:0] count, len, rd_ptr;
   logic [TW-1:0] timer;
   logic          in_ready, accept, close, drop, timeout_hit;
   logic          rd_en, out_valid, out_last, pay_hs;
   logic [7:0]    out_data;
   logic [31:0]   src_ip, dst_ip;
   logic [15:0]   src_port, dst_port;

   assign accept      = s_axis_tvalid && in_ready;
   assign pay_hs      = out_valid && m_udp_payload_axis_tready;
   assign timeout_hit = TIMEOUT_EN && (state == S_FILL) && !accept && (timer == TIMER_LAST);
   assign rd_en       = (state == S_PAYLOAD) && (!out_valid || m_udp_payload_axis_tready) &&
                        (rd_ptr != len);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      close      = 1'b0;
      drop       = 1'b0;
      case (state)
         S_IDLE, S_FILL: begin
            if (accept) begin
               if (s_axis_tlast && s_axis_tuser) begin
                  drop       = 1'b1;
                  state_next = S_IDLE;
               end else if (s_axis_tlast || (count == COUNT_LAST)) begin
                  close      = 1'b1;
                  state_next = S_HDR;
               end else begin
                  state_next = S_FILL;
               end
            end else if (timeout_hit) begin
               close      = 1'b1;
               state_next = S_HDR;
            end
         end
         S_HDR:     if (m_udp_hdr_ready) state_next = S_PAYLOAD;
         S_PAYLOAD: if (pay_hs && out_last) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         in_ready <= 1'b0;
         count    <= '0;
         timer    <= '0;
         len      <= '0;
         src_ip   <= '0;
         dst_ip   <= '0;
         src_port <= '0;
         dst_port <= '0;
      end else begin
         state    <= state_next;
         in_ready <= (state_next == S_IDLE) || (state_next == S_FILL);
         if (accept) count <= (close || drop) ? '0 : count + 1'b1;
         else if (close) count <= '0;
         if ((state == S_FILL) && !accept && !close) timer <= timer + 1'b1;
         else timer <= '0;
         if (close) begin
            len      <= accept ? count + 1'b1 : count;
            src_ip   <= local_ip;
            dst_ip   <= remote_ip;
            src_port <= local_port;
            dst_port <= remote_port;
         end
      end
   end

   // Output register refills on the same edge a byte is taken, so a ready sink sees no bubbles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         rd_ptr    <= '0;
      end else if (state != S_PAYLOAD) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         rd_ptr    <= '0;
      end else if (!out_valid || m_udp_payload_axis_tready) begin
         out_valid <= rd_en;
         out_last  <= rd_en && (rd_ptr == len - CW'(1));
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the payload buffer and its read register are deliberately not reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (accept) buffer[count[AW-1:0]] <= s_axis_tdata;
      if (rd_en) out_data <= buffer[rd_ptr[AW-1:0]];
   end

`ifdef UDP_TX_PACKETIZER_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_datagrams <= '0;
         stat_bytes     <= '0;
         stat_drops     <= '0;
      end else begin
         if (pay_hs && out_last) stat_datagrams <= stat_datagrams + 1'b1;
         if (pay_hs) stat_bytes <= stat_bytes + 1'b1;
         if (drop) stat_drops <= stat_drops + 1'b1;
      end
   end
`endif

   assign s_axis_tready             = in_ready;
   assign m_udp_hdr_valid           = (state == S_HDR);
   assign m_udp_ip_dscp             = 6'd0;
   assign m_udp_ip_ecn              = 2'd0;
   assign m_udp_ip_ttl              = 8'(IP_TTL);
   assign m_udp_ip_source_ip        = src_ip;
   assign m_udp_ip_dest_ip          = dst_ip;
   assign m_udp_source_port         = src_port;
   assign m_udp_dest_port           = dst_port;
   assign m_udp_length              = 16'(len) + 16'd8;
   assign m_udp_checksum            = 16'd0;
   assign m_udp_payload_axis_tdata  = out_data;
   assign m_udp_payload_axis_tvalid = out_valid;
   assign m_udp_payload_axis_tlast  = out_last;
   assign m_udp_payload_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Self-checking bench for udp_tx_packetizer: directed vector table, corner sequences and
// randomized traffic compared against a datagram-level reference model.
module tb_udp_tx_packetizer;

   localparam int MAXP = 64;
   localparam int TMO  = 100;
   localparam int TTL  = 64;

   typedef struct packed {
      logic [31:0] sip;
      logic [31:0] dip;
      logic [15:0] sp;
      logic [15:0] dp;
      logic [15:0] len;
   } hdr_t;

   typedef struct {
      int n;
      bit user;
      int exp_len;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
   logic        s_tready;
   logic [31:0] cfg_lip = '0, cfg_rip = '0;
   logic [15:0] cfg_lp = '0, cfg_rp = '0;
   logic        hdr_valid, hdr_ready = 1'b1;
   logic [5:0]  dscp;
   logic [1:0]  ecn;
   logic [7:0]  ttl;
   logic [31:0] src_ip, dst_ip;
   logic [15:0] sport, dport, ulen, csum;
   logic [7:0]  p_data;
   logic        p_valid, p_ready = 1'b1, p_last, p_user;

   int tests = 0, fails = 0, cyc = 0;
   int frames_rx = 0, last_rx_len = 0, hdr_rise_cyc = 0, last_acc_cyc = 0, bp_mode = 0;
   bit mon_in_frame = 1'b0;

   hdr_t       exp_hdr[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] cur[$];

   udp_tx_packetizer #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO), .IP_TTL(TTL)) dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .local_ip(cfg_lip), .remote_ip(cfg_rip), .local_port(cfg_lp), .remote_port(cfg_rp),
      .m_udp_hdr_valid(hdr_valid), .m_udp_hdr_ready(hdr_ready),
      .m_udp_ip_dscp(dscp), .m_udp_ip_ecn(ecn), .m_udp_ip_ttl(ttl),
      .m_udp_ip_source_ip(src_ip), .m_udp_ip_dest_ip(dst_ip),
      .m_udp_source_port(sport), .m_udp_dest_port(dport),
      .m_udp_length(ulen), .m_udp_checksum(csum),
      .m_udp_payload_axis_tdata(p_data), .m_udp_payload_axis_tvalid(p_valid),
      .m_udp_payload_axis_tready(p_ready), .m_udp_payload_axis_tlast(p_last),
      .m_udp_payload_axis_tuser(p_user)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: whole datagrams, closed by tlast, by reaching MAXP bytes, or by the caller on idle.
   task automatic model_close();
      hdr_t h;
      if (cur.size() == 0) return;
      h.sip = cfg_lip;
      h.dip = cfg_rip;
      h.sp  = cfg_lp;
      h.dp  = cfg_rp;
      h.len = 16'(cur.size() + 8);
      exp_hdr.push_back(h);
      foreach (cur[i]) exp_bytes.push_back(cur[i]);
      cur.delete();
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last, input bit user);
      int n = 0;
      s_tdata = d; s_tvalid = 1'b1; s_tlast = last; s_tuser = user;
      do begin
         @(negedge clk);
         n++;
      end while (!s_tready && n < 3000);
      check("in_accept_wait", n < 3000, 1);
      if (s_tready) begin
         if (last && user) cur.delete();
         else begin
            cur.push_back(d);
            if (last || cur.size() == MAXP) model_close();
         end
         last_acc_cyc = cyc;
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic set_cfg();
      cfg_lip = $urandom; cfg_rip = $urandom;
      cfg_lp = 16'($urandom); cfg_rp = 16'($urandom);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_hdr.size() != 0 || exp_bytes.size() != 0 || mon_in_frame) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", n < budget, 1);
      idle(5);
   endtask

   task automatic bp_driver();
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            1: begin
               hdr_ready = ($urandom_range(0, 2) == 0);
               p_ready   = ($urandom_range(0, 1) == 0);
            end
            2: begin
               hdr_ready = 1'b1;
               p_ready   = 1'b0;
            end
            default: begin
               hdr_ready = 1'b1;
               p_ready   = 1'b1;
            end
         endcase
      end
   endtask

   task automatic monitor();
      hdr_t       h, prev_h;
      logic [8:0] prev_p = '0;
      logic [7:0] eb;
      bit prev_hstall = 0, prev_pstall = 0, prev_hv = 0, prev_nonlast = 0, wait_first = 0;
      int idx = 0, hs_cyc = 0, cur_len = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_hstall = 0; prev_pstall = 0; prev_hv = 0; prev_nonlast = 0; wait_first = 0;
            idx = 0; mon_in_frame = 1'b0;
            continue;
         end
         if (hdr_valid || p_valid) check("in_ready_low_while_busy", s_tready, 0);
         if (prev_hstall)
            check("hdr_stable", {hdr_valid, src_ip, dst_ip, sport, dport, ulen}, {1'b1, prev_h});
         if (prev_pstall) check("payload_stable", {p_valid, p_last, p_data}, {1'b1, prev_p});
         if (prev_nonlast) check("payload_no_bubble", p_valid, 1);
         if (hdr_valid && !prev_hv) hdr_rise_cyc = cyc;
         if (wait_first && p_valid) begin
            check("first_valid_latency", (cyc - hs_cyc) <= 2, 1);
            wait_first = 0;
         end
         prev_hstall  = hdr_valid && !hdr_ready;
         prev_h       = {src_ip, dst_ip, sport, dport, ulen};
         prev_pstall  = p_valid && !p_ready;
         prev_p       = {p_last, p_data};
         prev_hv      = hdr_valid;
         prev_nonlast = p_valid && p_ready && !p_last;
         if (hdr_valid && hdr_ready) begin
            check("hdr_expected", exp_hdr.size() != 0, 1);
            check("hdr_const", {ttl, dscp, ecn, csum, p_user}, {8'(TTL), 6'd0, 2'd0, 16'd0, 1'b0});
            check("hdr_after_prev_payload", mon_in_frame, 0);
            cur_len = int'(ulen) - 8;
            if (exp_hdr.size() != 0) begin
               h = exp_hdr.pop_front();
               check("hdr_fields", {src_ip, dst_ip, sport, dport, ulen}, h);
               cur_len = int'(h.len) - 8;
            end
            mon_in_frame = 1'b1;
            idx          = 0;
            hs_cyc       = cyc;
            wait_first   = 1;
            last_rx_len  = int'(ulen);
         end
         if (p_valid && p_ready) begin
            check("payload_in_frame", mon_in_frame, 1);
            check("payload_expected", exp_bytes.size() != 0, 1);
            if (exp_bytes.size() != 0) begin
               eb = exp_bytes.pop_front();
               check("payload_byte", p_data, eb);
            end
            check("payload_tlast", p_last, idx == cur_len - 1);
            idx++;
            if (p_last) begin
               mon_in_frame = 1'b0;
               frames_rx++;
            end
         end
      end
   endtask

   initial begin
      vec_t vecs[6];
      int   f0, n, acc, lat;
      vecs[0] = '{5,  1'b0, 13};
      vecs[1] = '{1,  1'b0, 9};
      vecs[2] = '{2,  1'b0, 10};
      vecs[3] = '{63, 1'b0, 71};
      vecs[4] = '{64, 1'b0, 72};
      vecs[5] = '{4,  1'b1, 0};

      fork
         monitor();
         bp_driver();
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_valids", {s_tready, hdr_valid, p_valid, p_last}, 4'b0);
      check("reset_hdr_fields", {src_ip, dst_ip, sport, dport}, '0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("ready_after_reset", s_tready, 1);
      @(posedge clk); #1;

      // Directed vectors: bytes 1..n, tlast on the last byte, optional tuser drop
      for (int v = 0; v < 6; v++) begin
         f0 = frames_rx;
         set_cfg();
         for (int i = 0; i < vecs[v].n; i++)
            send_byte(8'(i + 1), i == vecs[v].n - 1, vecs[v].user && (i == vecs[v].n - 1));
         drain(2000);
         check($sformatf("vec%0d_frames", v), frames_rx - f0, vecs[v].exp_len != 0);
         if (vecs[v].exp_len != 0) check($sformatf("vec%0d_len", v), last_rx_len, vecs[v].exp_len);
      end

      // MAXP+4 bytes without tlast: full datagram, then the 4-byte tail closes on timeout
      f0 = frames_rx;
      set_cfg();
      for (int i = 0; i < MAXP + 4; i++) send_byte(8'($urandom), 1'b0, 1'b0);
      model_close();
      drain(2000);
      check("maxp_frames", frames_rx - f0, 2);
      check("maxp_tail_len", last_rx_len, 12);

      // Idle timeout: 3 bytes then silence
      f0 = frames_rx;
      set_cfg();
      for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
      acc = last_acc_cyc;
      model_close();
      drain(1000);
      lat = hdr_rise_cyc - acc;
      check("timeout_frames", frames_rx - f0, 1);
      check("timeout_len", last_rx_len, 11);
      check("timeout_latency_in_101_102", (lat >= TMO + 1) && (lat <= TMO + 2), 1);

      // Dropped datagram followed by a 2-byte datagram
      f0 = frames_rx;
      set_cfg();
      for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), i == 3, i == 3);
      for (int i = 0; i < 2; i++) send_byte(8'h20 + 8'(i), i == 1, 1'b0);
      drain(1000);
      check("drop_frames", frames_rx - f0, 1);
      check("drop_len", last_rx_len, 10);

      // Random backpressure: one 64-byte datagram plus random-length datagrams
      bp_mode = 1;
      f0 = frames_rx;
      set_cfg();
      for (int i = 0; i < MAXP; i++) send_byte(8'($urandom), i == MAXP - 1, 1'b0);
      for (int d = 0; d < 20; d++) begin
         n = $urandom_range(1, MAXP);
         set_cfg();
         for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n - 1, 1'b0);
         idle($urandom_range(0, 3));
      end
      drain(5000);
      check("random_frames", frames_rx - f0, 21);
      bp_mode = 0;
      idle(2);

      // Reset while a payload is stalled
      bp_mode = 2;
      set_cfg();
      for (int i = 0; i < 20; i++) send_byte(8'($urandom), i == 19, 1'b0);
      n = 0;
      while (!p_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reset_test_payload_seen", p_valid, 1);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("async_reset_outputs", {s_tready, hdr_valid, p_valid, p_last}, 4'b0);
      exp_hdr.delete();
      exp_bytes.delete();
      cur.delete();
      bp_mode = 0;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      f0 = frames_rx;
      set_cfg();
      for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), i == 6, 1'b0);
      drain(1000);
      check("post_reset_frames", frames_rx - f0, 1);
      check("post_reset_len", last_rx_len, 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
